fetch_trace_buffer: RTL
=======================

# fetch_trace_buffer

Circular capture buffer between the instruction fetch unit and the two-number seven-segment display driver. In live mode it records the (PC, instruction) pair on every fetch advance and presents the newest pair. When frozen it stops capturing and lets the operator step backwards through history with a debounced push-button. Display outputs carry the low 16 bits of the instruction and PC.

## Interface
- DEPTH, 16: number of entries; power of two, 2..256
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a button level (10 ms at 100 MHz)
- Clk  input  1  system clock; the only clock
- Reset  input  1  asynchronous, active-high; clears all state
- FetchTick  input  1  one-Clk-cycle pulse marking a fetch advance; Instruction and PCResult are valid in that cycle
- Instruction  input  32  fetched instruction word; bits [15:0] are stored
- PCResult  input  32  current PC; bits [15:0] are stored
- Freeze  input  1  level; high selects FROZEN mode (switch, already stable)
- BtnStep  input  1  raw, asynchronous push-button
- NumberA  output  16  instruction[15:0] of the displayed entry
- NumberB  output  16  PC[15:0] of the displayed entry
- Count  output  $clog2(DEPTH)+1  valid entries, saturating at DEPTH
- Frozen  output  1  high in FROZEN state
- Wrapped  output  1  sticky; an entry was overwritten

## Operation
- States:
  - LIVE (reset state).
  - FROZEN.
- Transitions:
  - LIVE→FROZEN on the edge where Freeze=1.
  - FROZEN→LIVE on the edge where Freeze=0.
  - Evaluated every cycle.
- Capture:
  - Occurs only when the registered state is LIVE and FetchTick=1.
  - Writes {Instruction[15:0], PCResult[15:0]} at wr_ptr, then wr_ptr increments mod DEPTH.
  - Count increments, saturating at DEPTH.
  - A capture made when Count==DEPTH sets Wrapped; only Reset clears it.
- Simultaneous FetchTick and Freeze rising: the tick is captured, and the state becomes FROZEN on the same edge.
- Displayed entry is buf[(wr_ptr−1−offset) mod DEPTH], where offset ranges 0..Count−1:
  - In LIVE, offset is held at 0.
  - On entry to FROZEN, offset is 0.
  - Each accepted step in FROZEN increments offset. From Count−1 it wraps to 0 (newest).
  - Steps in LIVE are discarded.
- Count==0: NumberA=NumberB=0 regardless of state.
- Returning to LIVE does not clear history; capture resumes at wr_ptr.
- Debouncer:
  - 2-flop synchronizer feeds a counter.
  - The stable level changes only after DEBOUNCE_CYCLES consecutive samples that differ from it.
  - A 0→1 change of the stable level produces a single one-cycle step pulse.
  - Holding the button produces exactly one step.
- Arithmetic:
  - Pointer and offset math is modulo DEPTH, unsigned.
  - Count is one bit wider than the pointer, so it can represent DEPTH.

## Timing
- Reset values: NumberA=0, NumberB=0, Count=0, Frozen=0, Wrapped=0; state LIVE; wr_ptr=0; offset=0; debouncer stable level=0 and counter=0. Buffer RAM is not cleared, because Count=0 masks it.
- Reset asserted mid-operation, including mid-debounce: all outputs go to their reset values asynchronously. Operation resumes on the first Clk edge after deassertion.
- Capture latency: a FetchTick at edge N updates Count/Wrapped at edge N. In LIVE, NumberA/NumberB show that entry after edge N+1 (registered read).
- Freeze latency: Freeze high before edge N gives Frozen=1 after edge N. Outputs are stable from edge N+1.
- Step latency: the raw button must be stable for 2 + DEBOUNCE_CYCLES edges before the pulse. The offset updates at the pulse edge, and outputs follow one edge later.
- FetchTick pulses may arrive back to back (every cycle); every one is captured in LIVE.

## Structure
- Shared package trace_pkg holds:
  - the state encoding constants (ST_LIVE=0, ST_FROZEN=1);
  - default DEPTH;
  - default DEBOUNCE_CYCLES.
- One sub-module, button_debounce (parameters DEBOUNCE_CYCLES; ports Clk, Reset, BtnIn, Level, RisePulse), which is reusable for other board buttons.
- Storage is an inferred DEPTH×32 register array with a synchronous write and a registered read, fitting LUTRAM/FFs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and DEPTH=4.
- Reset then 3 FetchTicks with (PC, instr) = (0x0000,0x1111), (0x0004,0x2222), (0x0008,0x3333) → Count=3, Wrapped=0, NumberA=0x3333, NumberB=0x0008 one cycle after the last tick.
- 6 ticks with PCs 0,4,8,C,10,14 → Count=4, Wrapped=1; freeze then step 3 times → NumberB shows 0x14, 0x10, 0xC, 0x8; a fourth step → back to 0x14.
- Freeze rises in the same cycle as a tick with PC=0x20 → entry captured, Frozen=1, NumberB=0x20. Further ticks while frozen leave Count and NumberB unchanged.
- BtnStep bounce pattern (1,0,1,0 each one cycle) then held high for 10 cycles → exactly one step. Held high for 50 cycles → no further step.
- Reset asserted while frozen with offset=2 and the debouncer mid-count → all outputs 0 immediately, Frozen=0. After release, a tick with PC=0x40 gives Count=1 and NumberB=0x40.
- Count=0, freeze and step → NumberA=NumberB=0, offset stays 0, no X on outputs.

Source files
------------

// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the fetch trace buffer and its helpers:
//   - trace_state_e : capture state encoding (ST_LIVE = 0, ST_FROZEN = 1)
//   - DEFAULT_DEPTH : default number of trace entries
//   - DEFAULT_DEBOUNCE_CYCLES : default push-button settle time in Clk cycles
//                               (10 ms at 100 MHz)
// -----------------------------------------------------------------------------
package trace_pkg;

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_FROZEN = 1'b1
  } trace_state_e;

  localparam int DEFAULT_DEPTH           = 16;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage : trace_pkg

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Synchronises a raw asynchronous push-button and filters contact bounce.
// The stable level only moves once the synchronised input has disagreed with
// it for DEBOUNCE_CYCLES consecutive samples; a 0->1 move of the stable level
// produces a single one-cycle RisePulse, so a held button yields one pulse.
//
// Ports:
//   Clk       in   system clock
//   Reset     in   asynchronous, active-high; clears synchroniser and counter
//   BtnIn     in   raw button (asynchronous to Clk)
//   Level     out  debounced button level (registered)
//   RisePulse out  one-cycle pulse on a 0->1 change of Level (registered)
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnIn,
  output logic Level,
  output logic RisePulse
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  // Next-state logic: shift the synchroniser and count disagreeing samples.
  always_comb begin
    sync_d  = {sync_q[0], BtnIn};
    level_d = level_q;
    cnt_d   = CNT_ZERO;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        level_d = sync_q[1];
        cnt_d   = CNT_ZERO;
        rise_d  = sync_q[1];
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
      end
    end else begin
      // Any agreeing sample restarts the settle window.
      cnt_d = CNT_ZERO;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign Level     = level_q;
  assign RisePulse = rise_q;

endmodule : button_debounce

// File: rtl/fetch_trace_buffer.sv
// -----------------------------------------------------------------------------
// fetch_trace_buffer
// Circular history of (PC, instruction) pairs sitting between the fetch unit
// and the two-number seven-segment display driver. In LIVE mode every fetch
// advance is recorded and the newest pair is displayed. In FROZEN mode capture
// stops and each debounced button press steps one entry further back in
// history, wrapping from the oldest valid entry back to the newest.
//
// Ports:
//   Clk          in   system clock
//   Reset        in   asynchronous, active-high
//   FetchTick    in   one-cycle fetch advance strobe
//   Instruction  in   fetched instruction; [15:0] stored
//   PCResult     in   current PC; [15:0] stored
//   Freeze       in   level; 1 = FROZEN
//   BtnStep      in   raw step push-button
//   NumberA      out  instruction[15:0] of displayed entry (registered)
//   NumberB      out  PC[15:0] of displayed entry (registered)
//   Count        out  valid entries, saturating at DEPTH
//   Frozen       out  1 while in FROZEN
//   Wrapped      out  sticky: an entry has been overwritten
// -----------------------------------------------------------------------------
module fetch_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH           = DEFAULT_DEPTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     FetchTick,
  input  logic [31:0]              Instruction,
  input  logic [31:0]              PCResult,
  input  logic                     Freeze,
  input  logic                     BtnStep,
  output logic [15:0]              NumberA,
  output logic [15:0]              NumberB,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Frozen,
  output logic                     Wrapped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] COUNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

  trace_state_e     state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] offset_q, offset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic [31:0]      rd_data_q, rd_data_d;

  logic [31:0]      mem_q [DEPTH];

  logic             capture_s;
  logic             step_s;
  logic             btn_level_s;
  logic [PTR_W-1:0] rd_addr_s;
  logic [31:0]      wr_data_s;

  // Upper halves of the fetch buses and the debounced level are not needed
  // here; fold them into one named sink so they are visibly intentional.
  logic             unused_inputs_s;
  assign unused_inputs_s = ^{Instruction[31:16], PCResult[31:16], btn_level_s};

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .Clk       (Clk),
    .Reset     (Reset),
    .BtnIn     (BtnStep),
    .Level     (btn_level_s),
    .RisePulse (step_s)
  );

  // Control next-state: mode, capture pointer/count, wrap flag, step offset.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    offset_d  = offset_q;
    wr_data_s = {Instruction[15:0], PCResult[15:0]};

    if (Freeze) begin
      state_d = ST_FROZEN;
    end else begin
      state_d = ST_LIVE;
    end

    // Capture is gated by the registered state, so a tick coinciding with
    // the Freeze rise is still recorded.
    capture_s = (state_q == ST_LIVE) && FetchTick;

    if (capture_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (count_q == COUNT_FULL) begin
        count_d   = count_q;
        wrapped_d = 1'b1;
      end else begin
        count_d   = count_q + COUNT_ONE;
        wrapped_d = wrapped_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Offset is pinned to the newest entry whenever we are (or are going)
    // LIVE; steps only count while already FROZEN, and wrap at Count-1.
    if (state_d == ST_LIVE) begin
      offset_d = PTR_ZERO;
    end else if ((state_q == ST_FROZEN) && step_s) begin
      if ((count_q == COUNT_ZERO) || ({1'b0, offset_q} == (count_q - COUNT_ONE))) begin
        offset_d = PTR_ZERO;
      end else begin
        offset_d = offset_q + PTR_ONE;
      end
    end else begin
      offset_d = offset_q;
    end
  end

  // Read path: newest-minus-offset entry, masked to zero while empty.
  always_comb begin
    rd_addr_s = wr_ptr_q - PTR_ONE - offset_q;
    if (count_q == COUNT_ZERO) begin
      rd_data_d = 32'h0000_0000;
    end else begin
      rd_data_d = mem_q[rd_addr_s];
    end
  end

  // Control and display registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_LIVE;
      wr_ptr_q  <= PTR_ZERO;
      offset_q  <= PTR_ZERO;
      count_q   <= COUNT_ZERO;
      wrapped_q <= 1'b0;
      rd_data_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      offset_q  <= offset_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Trace storage: synchronous write, no reset (Count masks stale contents).
  always_ff @(posedge Clk) begin
    if (capture_s) begin
      mem_q[wr_ptr_q] <= wr_data_s;
    end
  end

  assign NumberA = rd_data_q[31:16];
  assign NumberB = rd_data_q[15:0];
  assign Count   = count_q;
  assign Frozen  = (state_q == ST_FROZEN);
  assign Wrapped = wrapped_q;

endmodule : fetch_trace_buffer
